// File: rtl/fetch_decode_unit_if.sv
// Handshake and program-load bundle between the fetch/decode unit and its environment.
interface fetch_decode_unit_if;
  logic        start;
  logic        stop;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic        eu_ready;
  logic        issue_valid;
  logic [3:0]  opcode;
  logic [3:0]  addr1;
  logic [3:0]  addr2;
  logic [3:0]  addr3;
  logic [3:0]  pc;
  logic        busy;
  logic        halted;

  modport slave (
    input  start, stop, load_en, load_addr, load_data, eu_ready,
    output issue_valid, opcode, addr1, addr2, addr3, pc, busy, halted
  );

  modport master (
    output start, stop, load_en, load_addr, load_data, eu_ready,
    input  issue_valid, opcode, addr1, addr2, addr3, pc, busy, halted
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// Fetch/decode unit: 16-word imem, IDLE/FETCH/DECODE/ISSUE FSM, valid/ready issue port.
// Optional FDU_HALT_EN: opcode F ends the run in DECODE instead of issuing.
module fetch_decode_unit #(
  parameter logic [3:0] START_PC   = 4'h0,
  parameter int         IMEM_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_decode_unit_if.slave bus
);

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] addr1;
    logic [3:0] addr2;
    logic [3:0] addr3;
  } instr_t;

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, ISSUE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  instr_t      ir_q, ir_d;
  instr_t      dec_q, dec_d;
  logic        vld_q, vld_d;
  logic        stop_q, stop_d;
  logic        is_halt;
  logic        imem_we;
  logic [15:0] imem_q [IMEM_DEPTH];

  // Program memory is deliberately outside reset so a reset never loses the program.
  assign imem_we = (state_q == IDLE) && bus.load_en;

  always_ff @(posedge clk) begin
    if (imem_we) imem_q[bus.load_addr] <= bus.load_data;
  end

`ifdef FDU_HALT_EN
  logic halted_q, halted_d;
  assign is_halt = (ir_q.opcode == 4'hF);

  always_comb begin
    halted_d = halted_q;
    if (state_q == IDLE && bus.start)      halted_d = 1'b0;
    else if (state_q == DECODE && is_halt) halted_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

  assign bus.halted = halted_q;
`else
  assign is_halt    = 1'b0;
  assign bus.halted = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    dec_d   = dec_q;
    vld_d   = vld_q;
    stop_d  = stop_q | ((state_q != IDLE) && bus.stop);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pc_d    = START_PC;
          state_d = FETCH;
        end
      end
      FETCH: begin
        ir_d    = instr_t'(imem_q[pc_q]);
        state_d = DECODE;
      end
      DECODE: begin
        if (is_halt) begin
          state_d = IDLE;
        end else begin
          dec_d   = ir_q;
          vld_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.eu_ready) begin
          vld_d   = 1'b0;
          pc_d    = pc_q + 4'd1;
          state_d = (stop_q || bus.stop) ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    // A pending stop is consumed by the return to IDLE.
    if (state_d == IDLE) stop_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      ir_q    <= '0;
      dec_q   <= '0;
      vld_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      dec_q   <= dec_d;
      vld_q   <= vld_d;
      stop_q  <= stop_d;
    end
  end

  assign bus.issue_valid = vld_q;
  assign bus.opcode      = dec_q.opcode;
  assign bus.addr1       = dec_q.addr1;
  assign bus.addr2       = dec_q.addr2;
  assign bus.addr3       = dec_q.addr3;
  assign bus.pc          = pc_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit; expectations follow the FETCH/DECODE/ISSUE timing.
module tb_fetch_decode_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] prog [16];

  fetch_decode_unit_if bus ();

  fetch_decode_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word();
    return {bus.opcode, bus.addr1, bus.addr2, bus.addr3};
  endfunction

  initial begin
    prog = '{16'h1234, 16'h5678, 16'h29AB, 16'h3C01, 16'h4D12, 16'h5E23, 16'h6F34, 16'h7045,
             16'h8156, 16'h9267, 16'hA378, 16'hB489, 16'hC59A, 16'hD6AB, 16'hE7BC, 16'h08CD};
    bus.start = 1'b0; bus.stop = 1'b0; bus.load_en = 1'b0;
    bus.load_addr = 4'h0; bus.load_data = 16'h0; bus.eu_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", 16'(bus.issue_valid), 16'h0);
    chk("rst_busy",  16'(bus.busy), 16'h0);
    chk("rst_pc",    16'(bus.pc), 16'h0);
    chk("rst_halt",  16'(bus.halted), 16'h0);
    chk("rst_word",  word(), 16'h0);
    rst_n = 1'b1;
    tick();

    // Program load
    for (int i = 0; i < 16; i++) begin
      bus.load_en = 1'b1; bus.load_addr = 4'(i); bus.load_data = prog[i];
      tick();
    end
    bus.load_en = 1'b0;

    // First issue latency and hold under backpressure
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("k0_busy",  16'(bus.busy), 16'h1);
    chk("k0_valid", 16'(bus.issue_valid), 16'h0);
    tick();
    chk("k1_valid", 16'(bus.issue_valid), 16'h0);
    tick();
    chk("k2_valid", 16'(bus.issue_valid), 16'h1);
    chk("k2_word",  word(), 16'h1234);
    chk("k2_pc",    16'(bus.pc), 16'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_valid", 16'(bus.issue_valid), 16'h1);
      chk("hold_word",  word(), 16'h1234);
      chk("hold_pc",    16'(bus.pc), 16'h0);
    end

    // Streaming run through the pc wrap
    bus.eu_ready = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      chk("hs_valid", 16'(bus.issue_valid), 16'h0);
      chk("hs_pc",    16'(bus.pc), 16'(n % 16));
      tick();
      chk("gap_valid", 16'(bus.issue_valid), 16'h0);
      tick();
      chk("run_valid", 16'(bus.issue_valid), 16'h1);
      chk("run_pc",    16'(bus.pc), 16'(n % 16));
      chk("run_word",  word(), prog[n % 16]);
    end

    // Stop pulsed in FETCH takes effect at the next handshake
    tick();
    chk("f_pc", 16'(bus.pc), 16'h1);
    bus.eu_ready = 1'b0; bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick();
    chk("stp_valid", 16'(bus.issue_valid), 16'h1);
    chk("stp_word",  word(), 16'h5678);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stp_hold", 16'(bus.issue_valid), 16'h1);
      chk("stp_busy", 16'(bus.busy), 16'h1);
    end
    bus.eu_ready = 1'b1;
    tick();
    bus.eu_ready = 1'b0;
    chk("stp_idle",   16'(bus.busy), 16'h0);
    chk("stp_vdrop",  16'(bus.issue_valid), 16'h0);
    chk("stp_pc",     16'(bus.pc), 16'h2);
    tick();
    chk("stp_stay",   16'(bus.busy), 16'h0);

    // Reset mid-ISSUE; loads and starts while busy are ignored
    bus.start = 1'b1;
    tick();
    bus.load_en = 1'b1; bus.load_addr = 4'h0; bus.load_data = 16'hFFFF;
    tick();
    tick();
    chk("pre_rst_valid", 16'(bus.issue_valid), 16'h1);
    chk("pre_rst_word",  word(), 16'h1234);
    bus.load_en = 1'b0; bus.start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(bus.issue_valid), 16'h0);
    chk("mid_rst_busy",  16'(bus.busy), 16'h0);
    chk("mid_rst_pc",    16'(bus.pc), 16'h0);
    chk("mid_rst_word",  word(), 16'h0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("re_valid", 16'(bus.issue_valid), 16'h1);
    chk("re_word",  word(), 16'h1234);
    bus.eu_ready = 1'b1; bus.stop = 1'b1;
    tick();
    bus.eu_ready = 1'b0; bus.stop = 1'b0;
    chk("re_idle", 16'(bus.busy), 16'h0);

    // Load-with-start and HALT handling
    bus.load_en = 1'b1; bus.load_addr = 4'h2; bus.load_data = 16'hF000;
    tick();
    bus.load_addr = 4'h0; bus.load_data = 16'hA9B8; bus.start = 1'b1;
    tick();
    bus.load_en = 1'b0; bus.start = 1'b0; bus.eu_ready = 1'b1;
    tick();
    tick();
    chk("ls_word", word(), 16'hA9B8);
    tick(); tick(); tick();
    chk("h1_word", word(), 16'h5678);
    chk("h1_pc",   16'(bus.pc), 16'h1);
    tick(); tick(); tick();
`ifdef FDU_HALT_EN
    chk("halt_flag",  16'(bus.halted), 16'h1);
    chk("halt_busy",  16'(bus.busy), 16'h0);
    chk("halt_valid", 16'(bus.issue_valid), 16'h0);
    chk("halt_pc",    16'(bus.pc), 16'h2);
    bus.eu_ready = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("halt_clr", 16'(bus.halted), 16'h0);
`else
    chk("f_valid", 16'(bus.issue_valid), 16'h1);
    chk("f_word",  word(), 16'hF000);
    chk("f_pc2",   16'(bus.pc), 16'h2);
    chk("f_halt",  16'(bus.halted), 16'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_decode_unit.md
FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 SHALL have parameter START_PC, default 4'h0: PC value loaded on reset and on every accepted start.
REQ-002 SHALL have parameter IMEM_DEPTH, default 16: number of 16-bit instruction words; fixed at 16 for a 4-bit PC.
REQ-003 SHALL have the following ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- start  input  1  begin execution from START_PC; sampled only in IDLE.
- stop  input  1  return to IDLE after the current instruction is accepted.
- load_en  input  1  write load_data to imem[load_addr]; honoured only in IDLE.
- load_addr  input  4  program-load address.
- load_data  input  16  program-load word.
- eu_ready  input  1  downstream execution unit accepts the issued instruction.
- issue_valid  output  1  opcode and addr1..addr3 hold a valid instruction.
- opcode  output  4  instruction bits [15:12].
- addr1  output  4  source-A address, bits [11:8].
- addr2  output  4  source-B address, bits [7:4].
- addr3  output  4  destination address, bits [3:0].
- pc  output  4  address of the instruction being fetched or issued.
- busy  output  1  high whenever the state is not IDLE.
- halted  output  1  a HALT instruction ended the last run.

Function
REQ-004 SHALL implement a four-state FSM: IDLE, FETCH, DECODE, ISSUE.
REQ-005 IDLE: on start=1, SHALL set pc=START_PC, clear halted, and go to FETCH.
REQ-006 FETCH: SHALL register imem[pc] into an internal instruction register, then go to DECODE.
REQ-007 DECODE: SHALL load opcode/addr1/addr2/addr3 from the instruction register, set issue_valid=1, then go to ISSUE.
REQ-008 Latency: start sampled at edge k SHALL produce issue_valid=1 after edge k+2.
REQ-009 ISSUE: while issue_valid=1 and eu_ready=0, opcode, addr1..addr3 and pc SHALL hold stable.
REQ-010 ISSUE with eu_ready=1: at that edge SHALL clear issue_valid, set pc=(pc+1) mod 16, and go to FETCH (or IDLE if stop=1).
REQ-011 Throughput: at most one instruction per 3 cycles; the next issue_valid SHALL rise 2 edges after the handshake edge.
REQ-012 PC wrap: pc=4'hF SHALL advance to 4'h0 with no flag or stall.
REQ-013 stop outside ISSUE SHALL be latched and SHALL take effect at the next handshake; the latch SHALL clear on entry to IDLE.
REQ-014 start outside IDLE SHALL be ignored; load_en outside IDLE SHALL be ignored and leave imem unchanged.
REQ-015 load_en and start together in IDLE: the write SHALL occur at that edge and the following FETCH SHALL read the new data.
REQ-016 busy SHALL be combinationally (state != IDLE).

Reset
REQ-017 rst_n=0 SHALL immediately force: state=IDLE, issue_valid=0, opcode/addr1/addr2/addr3=0, pc=START_PC, busy=0, halted=0, stop latch=0.
REQ-018 Reset asserted mid-ISSUE SHALL drop issue_valid without a handshake; the instruction is discarded.
REQ-019 imem contents SHALL NOT be affected by reset.

Configuration
REQ-020 Macro FDU_HALT_EN defined: DECODE with opcode 4'hF SHALL NOT issue; SHALL set halted=1 and go to IDLE, with pc left at the HALT address.
REQ-021 Macro FDU_HALT_EN undefined: opcode 4'hF SHALL issue as a normal instruction, and halted SHALL be tied to 0.

Verification
REQ-022 Load imem[0]=16'h1234, start, eu_ready=1 -> issue_valid rises 2 edges after the start edge with opcode=1, addr1=2, addr2=3, addr3=4.
REQ-023 Hold eu_ready=0 for 5 cycles during ISSUE -> outputs stable; after the handshake, pc goes 0->1 and issue_valid drops for 2 cycles.
REQ-024 Run 17 instructions from START_PC=0 with eu_ready=1 -> pc sequence 0..15,0; the 17th instruction equals imem[0].
REQ-025 With FDU_HALT_EN defined and imem[2]=16'hF000 -> 2 issues, then halted=1, busy=0, pc=2; without the macro, imem[2] issues as opcode F.
REQ-026 Assert rst_n=0 during ISSUE, then release and start again -> issue_valid=0 immediately; imem unchanged, and after restart the instruction at START_PC is reissued.
REQ-027 stop pulse during FETCH, with eu_ready low for 3 cycles -> the instruction still issues; the machine goes to IDLE at the handshake with pc incremented.
